// File: rtl/result_fifo_out.sv
// Output-side result buffer: stores pooled words tagged with an end-of-image bit and
// serves them to a legacy (1-cycle latency) read-request reader; flags overflow and done.
module result_fifo_out #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 4,
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned HEIGHT       = 7,
  parameter int unsigned NUM_IMG      = 1,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DWIDTH-1:0] data_in,
  output logic              ready_out,
  input  logic              fifo_out_rdreq,
  output logic [DWIDTH:0]   fifo_out_data,
  output logic              fifo_out_empty,
  output logic [AW:0]       fifo_usedw,
  output logic              overflow,
  output logic              done
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] LastPix  = PW'(NPIX - 1);
  localparam logic [AW:0]   FullCnt  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   Margin   = (AW + 1)'(AFULL_MARGIN);
  localparam logic [31:0]   LastImg  = 32'(NUM_IMG - 1);

  logic [DWIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       usedw_q, usedw_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [31:0]       img_wr_cnt_q, img_wr_cnt_d;
  logic [31:0]       img_rd_cnt_q, img_rd_cnt_d;
  logic [DWIDTH:0]   data_q, data_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  logic              full, empty, wr_en, rd_en, last_flag;
  logic [DWIDTH:0]   rd_word;

  // Full and empty are judged on the pre-edge count, so a read never frees room for a
  // write in the same cycle.
  assign full      = (usedw_q == FullCnt);
  assign empty     = (usedw_q == '0);
  assign wr_en     = valid_in & ~full;
  assign rd_en     = fifo_out_rdreq & ~empty;
  assign last_flag = (pix_cnt_q == LastPix);
  assign rd_word   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    usedw_d      = usedw_q;
    pix_cnt_d    = pix_cnt_q;
    img_wr_cnt_d = img_wr_cnt_q;
    img_rd_cnt_d = img_rd_cnt_q;
    data_d       = data_q;
    overflow_d   = overflow_q;
    done_d       = done_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (last_flag) begin
        pix_cnt_d    = '0;
        img_wr_cnt_d = img_wr_cnt_q + 32'd1;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end else if (valid_in) begin
      overflow_d = 1'b1;
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = rd_word;
      if (rd_word[DWIDTH]) begin
        img_rd_cnt_d = img_rd_cnt_q + 32'd1;
        if (img_rd_cnt_q == LastImg) done_d = 1'b1;
      end
    end

    if (wr_en && !rd_en) begin
      usedw_d = usedw_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      usedw_d = usedw_q - 1'b1;
    end
  end

  // Storage is not reset; clearing the pointers and count discards its contents.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= {last_flag, data_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      usedw_q      <= '0;
      pix_cnt_q    <= '0;
      img_wr_cnt_q <= '0;
      img_rd_cnt_q <= '0;
      data_q       <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      usedw_q      <= usedw_d;
      pix_cnt_q    <= pix_cnt_d;
      img_wr_cnt_q <= img_wr_cnt_d;
      img_rd_cnt_q <= img_rd_cnt_d;
      data_q       <= data_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

  assign fifo_out_data  = data_q;
  assign fifo_out_empty = empty;
  assign fifo_usedw     = usedw_q;
  assign ready_out      = (FullCnt - usedw_q) > Margin;
  assign overflow       = overflow_q;
  assign done           = done_q;

endmodule
